// File: rtl/clk_div_pkg.sv
// Shared definitions for the programmable clock divider: state encoding,
// minimum ratio and the ratio clamp helper.
package clk_div_pkg;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    localparam int unsigned C_DIV_MIN = 2;

    // Ratios below the minimum would leave no room for a low phase.
    function automatic logic [31:0] clamp_div(input logic [31:0] n);
        return (n < 32'(C_DIV_MIN)) ? 32'(C_DIV_MIN) : n;
    endfunction

endpackage

// File: rtl/clk_div_shadow.sv
// Valid/ready shadow register for a new divide ratio; holds the request
// pending until the top level signals that a commit point has arrived.
module clk_div_shadow
    import clk_div_pkg::*;
#(
    parameter int unsigned P_CNT_W = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [P_CNT_W-1:0] div,
    input  logic               div_valid,
    input  logic               commit_ok,
    output logic               div_ready,
    output logic [P_CNT_W-1:0] shadow_div,
    output logic               commit_c
);

    // Ready doubles as the inverse of the pending flag.
    assign commit_c = !div_ready && commit_ok;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            div_ready  <= 1'b1;
            shadow_div <= '0;
        end else if (div_valid && div_ready) begin
            shadow_div <= P_CNT_W'(clamp_div(32'(div)));
            div_ready  <= 1'b0;
        end else if (commit_c) begin
            div_ready  <= 1'b1;
        end
    end

endmodule

// File: rtl/clk_div_prog.sv
// Runtime-programmable clock divider: IDLE/RUN FSM, period counter and
// registered divided clock / tick outputs.
module clk_div_prog
    import clk_div_pkg::*;
#(
    parameter int unsigned P_CNT_W       = 16,
    parameter int unsigned P_DIV_DEFAULT = 2
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_en,
    input  logic [P_CNT_W-1:0] i_div,
    input  logic               i_div_valid,
    output logic               o_div_ready,
    output logic [P_CNT_W-1:0] o_div_cur,
    output logic               o_clk_div,
    output logic               o_tick,
    output logic               o_run
);

    localparam logic [P_CNT_W-1:0] C_DIV_RST = P_CNT_W'(clamp_div(32'(P_DIV_DEFAULT)));

    logic [0:0]         state;
    logic [0:0]         state_nxt;
    logic [P_CNT_W-1:0] cnt;
    logic [P_CNT_W-1:0] cnt_nxt;
    logic [P_CNT_W-1:0] div_nxt;
    logic [P_CNT_W-1:0] shadow_div;
    logic [P_CNT_W:0]   half_c;
    logic               boundary_c;
    logic               commit_ok_c;
    logic               commit_c;

    clk_div_shadow #(
        .P_CNT_W (P_CNT_W)
    ) u_shadow (
        .clk        (i_clk),
        .rst_n      (i_rst_n),
        .div        (i_div),
        .div_valid  (i_div_valid),
        .commit_ok  (commit_ok_c),
        .div_ready  (o_div_ready),
        .shadow_div (shadow_div),
        .commit_c   (commit_c)
    );

    // Threshold is one bit wider so the largest ratio cannot wrap.
    always_comb begin
        half_c      = ({1'b0, o_div_cur} + (P_CNT_W+1)'(1)) >> 1;
        boundary_c  = (state == ST_RUN) && (cnt == o_div_cur - P_CNT_W'(1));
        commit_ok_c = (state == ST_IDLE) || boundary_c;
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        div_nxt   = o_div_cur;
        if (commit_c) begin
            div_nxt = shadow_div;
        end
        case (state)
            ST_IDLE: begin
                cnt_nxt = '0;
                if (i_en) begin
                    state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                if (boundary_c) begin
                    cnt_nxt = '0;
                    if (!i_en) begin
                        state_nxt = ST_IDLE;
                    end
                end else begin
                    cnt_nxt = cnt + P_CNT_W'(1);
                end
            end
            default: begin
                state_nxt = ST_IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    // Outputs follow the counter by one edge so they stay fully registered.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            o_div_cur <= C_DIV_RST;
            o_clk_div <= 1'b0;
            o_tick    <= 1'b0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            o_div_cur <= div_nxt;
            o_clk_div <= (state == ST_RUN) && ({1'b0, cnt} < half_c);
            o_tick    <= (state == ST_RUN) && (cnt == '0);
        end
    end

    assign o_run = state[0];

endmodule

// File: tb/tb_clk_div_prog.sv
// Scoreboard bench for clk_div_prog: a waveform-queue reference model
// predicts every output after each edge; a monitor compares on the falling edge.
module tb_clk_div_prog;

    localparam int unsigned W   = 16;
    localparam int unsigned DEF = 4;

    bit            clk;
    logic          rst_n;
    logic          en;
    logic [W-1:0]  div;
    logic          div_valid;
    logic          div_ready;
    logic [W-1:0]  div_cur;
    logic          clk_div;
    logic          tick;
    logic          run;

    typedef struct packed {
        logic         clk_div;
        logic         tick;
        logic         run;
        logic         ready;
        logic [W-1:0] cur;
    } exp_t;

    exp_t sb[$];
    int   vectors     = 0;
    int   miscompares = 0;

    // Reference model: the current period is a queue of output levels.
    bit m_run;
    bit wave[$];
    int m_len;
    int m_cur;
    bit m_ready;
    int m_shadow;

    clk_div_prog #(
        .P_CNT_W       (W),
        .P_DIV_DEFAULT (DEF)
    ) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_en        (en),
        .i_div       (div),
        .i_div_valid (div_valid),
        .o_div_ready (div_ready),
        .o_div_cur   (div_cur),
        .o_clk_div   (clk_div),
        .o_tick      (tick),
        .o_run       (run)
    );

    initial forever #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic int clamp2(input int n);
        return (n < 2) ? 2 : n;
    endfunction

    task automatic new_period();
        wave.delete();
        m_len = m_cur;
        for (int i = 0; i < m_cur; i++) begin
            wave.push_back(i < (m_cur + 1) / 2);
        end
    endtask

    task automatic model_edge(input bit r, input bit e, input bit v, input int d);
        exp_t x;
        bit   bdry;
        bit   commit;
        bit   accept;
        if (!r) begin
            m_run     = 1'b0;
            wave.delete();
            m_cur     = clamp2(DEF);
            m_ready   = 1'b1;
            m_shadow  = 0;
            x.clk_div = 1'b0;
            x.tick    = 1'b0;
        end else begin
            x.clk_div = m_run ? wave[0] : 1'b0;
            x.tick    = m_run && (wave.size() == m_len);
            bdry      = m_run && (wave.size() == 1);
            commit    = !m_ready && (!m_run || bdry);
            accept    = v && m_ready;
            if (commit) begin
                m_cur   = m_shadow;
                m_ready = 1'b1;
            end
            if (accept) begin
                m_shadow = clamp2(d);
                m_ready  = 1'b0;
            end
            if (!m_run) begin
                if (e) begin
                    m_run = 1'b1;
                    new_period();
                end
            end else if (bdry) begin
                if (e) begin
                    new_period();
                end else begin
                    m_run = 1'b0;
                    wave.delete();
                end
            end else begin
                void'(wave.pop_front());
            end
        end
        x.run   = m_run;
        x.ready = m_ready;
        x.cur   = W'(m_cur);
        sb.push_back(x);
    endtask

    task automatic step(input bit r, input bit e, input bit v, input int d);
        rst_n     = r;
        en        = e;
        div_valid = v;
        div       = W'(d);
        model_edge(r, e, v, d);
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    // Monitor: one expected vector per edge, checked away from the rising edge.
    always @(negedge clk) begin
        exp_t x;
        if (sb.size() > 0) begin
            x = sb.pop_front();
            vectors++;
            chk("o_clk_div",   32'(clk_div),   32'(x.clk_div));
            chk("o_tick",      32'(tick),      32'(x.tick));
            chk("o_run",       32'(run),       32'(x.run));
            chk("o_div_ready", 32'(div_ready), 32'(x.ready));
            chk("o_div_cur",   32'(div_cur),   32'(x.cur));
        end
    end

    initial begin
        step(0, 0, 0, 0);
        step(0, 1, 1, 9);
        // Default ratio 4 straight out of reset.
        for (int i = 0; i < 24; i++) step(1, 1, 0, 0);
        for (int i = 0; i < 6; i++) step(1, 0, 0, 0);
        // Ratio 5 loaded in IDLE, then run.
        step(1, 0, 1, 5);
        step(1, 0, 0, 0);
        step(1, 0, 0, 0);
        for (int i = 0; i < 20; i++) step(1, 1, 0, 0);
        // Back to 4, then 7 mid-period.
        for (int i = 0; i < 6; i++) step(1, 1, 1, 4);
        for (int i = 0; i < 9; i++) step(1, 1, 0, 0);
        for (int i = 0; i < 10; i++) step(1, 1, 1, 7);
        for (int i = 0; i < 16; i++) step(1, 1, 0, 0);
        // Ratios 0 and 1 clamp to 2.
        for (int i = 0; i < 10; i++) step(1, 1, 1, 0);
        for (int i = 0; i < 8; i++) step(1, 1, 0, 0);
        for (int i = 0; i < 4; i++) step(1, 1, 1, 1);
        for (int i = 0; i < 8; i++) step(1, 1, 0, 0);
        // Ratio 6 then stop mid-period: no runt pulse.
        for (int i = 0; i < 6; i++) step(1, 1, 1, 6);
        for (int i = 0; i < 8; i++) step(1, 1, 0, 0);
        for (int i = 0; i < 12; i++) step(1, 0, 0, 0);
        // Ratio 9 then reset mid-period.
        step(1, 0, 1, 9);
        for (int i = 0; i < 12; i++) step(1, 1, 0, 0);
        step(0, 1, 0, 0);
        for (int i = 0; i < 6; i++) step(1, 1, 0, 0);
        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            bit r;
            bit e;
            bit v;
            int d;
            r = ($urandom_range(0, 199) != 0);
            e = ($urandom_range(0, 9) != 0);
            v = ($urandom_range(0, 3) == 0);
            d = ($urandom_range(0, 15) == 0) ? 40 : int'($urandom_range(0, 12));
            step(r, e, v, d);
        end
        step(1, 0, 0, 0);
        repeat (2) @(negedge clk);
        #1;
        chk("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
